// File: rtl/fft_iter_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_iter_addr_gen
//
// Address generator for an iterative, in-place radix-2 DIT FFT. It follows the
// control strobes of the FFT control unit and tracks the current layer (l) and
// butterfly index (b). From these it produces:
//   - the two data-RAM read addresses of the butterfly (A has a 0 inserted at
//     bit position l, B is A with bit l set),
//   - the twiddle-ROM index ((b mod 2^l) << (ButtWL-l)),
//   - write addresses, which are the read addresses delayed by WR_DELAY
//     enabled cycles to line up with the butterfly datapath.
//
// Optional build macro: FFT_ADDR_BITREV_EN
//   When defined, the read addresses of layer 0 are bit-reversed over ButtWL+1
//   bits so naturally ordered input data is fetched in DIT order. Write
//   addresses and the twiddle index always use the unreversed values.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset
//   EN          in   clock enable; all state holds while low
//   ADDR_RST    in   synchronous clear of butterfly/layer counters (wins)
//   ADDR_EN     in   advance butterfly counter
//   LAY_EN      in   advance layer counter
//   Wr          in   write phase, qualifies WR_VALID
//   RD_ADDR_A   out  upper-input read address        [ButtWL:0]
//   RD_ADDR_B   out  lower-input read address        [ButtWL:0]
//   WR_ADDR_A   out  delayed RD_ADDR_A               [ButtWL:0]
//   WR_ADDR_B   out  delayed RD_ADDR_B               [ButtWL:0]
//   WR_VALID    out  Wr and delay line full
//   TW_ADDR     out  twiddle ROM index               [ButtWL-1:0]
//   LAYER       out  registered layer counter        [LayWL-1:0]
//   LAST_LAY_O  out  high while LAYER == LAYERS-1
//   FFT_DONE    out  one-cycle pulse when the layer counter wraps
// ---------------------------------------------------------------------------
module fft_iter_addr_gen #(
    parameter int unsigned LAYERS      = 5,
    parameter int unsigned BUTTERFLYES = 16,
    parameter int unsigned LayWL       = 3,
    parameter int unsigned ButtWL      = 4,
    parameter int unsigned WR_DELAY    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              ADDR_RST,
    input  logic              ADDR_EN,
    input  logic              LAY_EN,
    input  logic              Wr,
    output logic [ButtWL:0]   RD_ADDR_A,
    output logic [ButtWL:0]   RD_ADDR_B,
    output logic [ButtWL:0]   WR_ADDR_A,
    output logic [ButtWL:0]   WR_ADDR_B,
    output logic              WR_VALID,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic [LayWL-1:0]  LAYER,
    output logic              LAST_LAY_O,
    output logic              FFT_DONE
);

    localparam int unsigned AW = ButtWL + 1;  // data RAM address width
    localparam int unsigned FW = 4;           // fill counter width, WR_DELAY <= 8

    // -----------------------------------------------------------------------
    // Configuration checks (elaboration time only)
    // -----------------------------------------------------------------------
    if (BUTTERFLYES > (1 << ButtWL)) begin : g_err_butt
        $error("fft_iter_addr_gen: BUTTERFLYES does not fit in ButtWL bits");
    end
    if (LAYERS > (1 << LayWL)) begin : g_err_lay
        $error("fft_iter_addr_gen: LAYERS does not fit in LayWL bits");
    end
    if ((WR_DELAY < 1) || (WR_DELAY > 8)) begin : g_err_dly
        $error("fft_iter_addr_gen: WR_DELAY must be in 1..8");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ButtWL-1:0] r_b;
    logic [LayWL-1:0]  r_l;

    logic [AW-1:0]     r_rd_a;      // unreversed read addresses
    logic [AW-1:0]     r_rd_b;
    logic [ButtWL-1:0] r_tw;
    logic [LayWL-1:0]  r_layer;
    logic              r_last;

    logic [2*AW-1:0]   r_dly [WR_DELAY];
    logic [FW-1:0]     r_fill;

`ifdef FFT_ADDR_BITREV_EN
    logic              r_rev;       // registered "address was for layer 0"
`endif

    // -----------------------------------------------------------------------
    // Combinational address function of (b, l)
    // -----------------------------------------------------------------------
    logic [AW-1:0]     w_b_ext;
    logic [AW-1:0]     w_lo_mask;
    logic [AW-1:0]     w_a;
    logic [AW-1:0]     w_bb;
    logic [7:0]        w_tw_sh;
    logic [ButtWL-1:0] w_tw;
    logic              w_b_last;
    logic              w_l_last;
    logic [ButtWL-1:0] w_b_nxt;
    logic [LayWL-1:0]  w_l_nxt;

    assign w_b_ext   = {1'b0, r_b};
    // Bits below position l stay in place; bits at or above l move up by one,
    // leaving a 0 at position l.
    assign w_lo_mask = ~({AW{1'b1}} << r_l);
    assign w_a       = ((w_b_ext & ~w_lo_mask) << 1) | (w_b_ext & w_lo_mask);
    assign w_bb      = w_a | ({{(AW - 1){1'b0}}, 1'b1} << r_l);

    // l never exceeds ButtWL in a legal configuration, so the shift is >= 0.
    assign w_tw_sh   = 8'(ButtWL) - 8'(r_l);
    assign w_tw      = (r_b & w_lo_mask[ButtWL-1:0]) << w_tw_sh;

    assign w_b_last  = (r_b == ButtWL'(BUTTERFLYES - 1));
    assign w_l_last  = (r_l == LayWL'(LAYERS - 1));
    assign w_b_nxt   = w_b_last ? '0 : r_b + 1'b1;
    assign w_l_nxt   = w_l_last ? '0 : r_l + 1'b1;

    // -----------------------------------------------------------------------
    // Butterfly / layer counters
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_b <= '0;
            r_l <= '0;
        end else if (EN) begin
            if (ADDR_RST) begin
                r_b <= '0;
                r_l <= '0;
            end else begin
                if (ADDR_EN) r_b <= w_b_nxt;
                if (LAY_EN)  r_l <= w_l_nxt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered read/twiddle addresses and layer status
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            r_layer <= '0;
            r_last  <= 1'b0;
        end else if (EN) begin
            r_rd_a  <= w_a;
            r_rd_b  <= w_bb;
            r_tw    <= w_tw;
            r_layer <= r_l;
            r_last  <= w_l_last;
        end
    end

`ifdef FFT_ADDR_BITREV_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rev <= 1'b0;
        end else if (EN) begin
            r_rev <= (r_l == '0);
        end
    end

    function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] i_v);
        logic [AW-1:0] v_r;
        v_r = '0;
        for (int i = 0; i < int'(AW); i++) begin
            v_r[AW-1-i] = i_v[i];
        end
        return v_r;
    endfunction

    assign RD_ADDR_A = r_rev ? f_bitrev(r_rd_a) : r_rd_a;
    assign RD_ADDR_B = r_rev ? f_bitrev(r_rd_b) : r_rd_b;
`else
    assign RD_ADDR_A = r_rd_a;
    assign RD_ADDR_B = r_rd_b;
`endif

    // -----------------------------------------------------------------------
    // Write-address delay line. Stage 0 captures the registered read address,
    // so the last stage shows the read address from WR_DELAY enabled cycles
    // earlier. ADDR_RST only empties the fill count; contents keep shifting.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(WR_DELAY); i++) begin
                r_dly[i] <= '0;
            end
        end else if (EN) begin
            r_dly[0] <= {r_rd_a, r_rd_b};
            for (int i = 1; i < int'(WR_DELAY); i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fill <= '0;
        end else if (EN) begin
            if (ADDR_RST) begin
                r_fill <= '0;
            end else if (r_fill != FW'(WR_DELAY)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign WR_ADDR_A  = r_dly[WR_DELAY-1][2*AW-1:AW];
    assign WR_ADDR_B  = r_dly[WR_DELAY-1][AW-1:0];
    assign WR_VALID   = Wr & (r_fill == FW'(WR_DELAY));
    assign TW_ADDR    = r_tw;
    assign LAYER      = r_layer;
    assign LAST_LAY_O = r_last;
    // Pulses in the cycle the wrapping LAY_EN is accepted.
    assign FFT_DONE   = EN & ~ADDR_RST & LAY_EN & w_l_last;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_fft_iter_addr_gen
//
// Self-checking bench: directed test-plan sequences followed by randomized
// control strobes, all compared every cycle against a behavioural model that
// computes addresses with integer arithmetic and keeps a log of every read
// address to derive the expected write addresses.
// ---------------------------------------------------------------------------
module tb_fft_iter_addr_gen;

    localparam int LAYERS      = 5;
    localparam int BUTTERFLYES = 16;
    localparam int LayWL       = 3;
    localparam int ButtWL      = 4;
    localparam int WR_DELAY    = 4;
    localparam int AW          = ButtWL + 1;

`ifdef FFT_ADDR_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              EN = 1'b0;
    logic              ADDR_RST = 1'b0;
    logic              ADDR_EN = 1'b0;
    logic              LAY_EN = 1'b0;
    logic              Wr = 1'b0;
    logic [ButtWL:0]   RD_ADDR_A;
    logic [ButtWL:0]   RD_ADDR_B;
    logic [ButtWL:0]   WR_ADDR_A;
    logic [ButtWL:0]   WR_ADDR_B;
    logic              WR_VALID;
    logic [ButtWL-1:0] TW_ADDR;
    logic [LayWL-1:0]  LAYER;
    logic              LAST_LAY_O;
    logic              FFT_DONE;

    fft_iter_addr_gen #(
        .LAYERS      (LAYERS),
        .BUTTERFLYES (BUTTERFLYES),
        .LayWL       (LayWL),
        .ButtWL      (ButtWL),
        .WR_DELAY    (WR_DELAY)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .ADDR_RST   (ADDR_RST),
        .ADDR_EN    (ADDR_EN),
        .LAY_EN     (LAY_EN),
        .Wr         (Wr),
        .RD_ADDR_A  (RD_ADDR_A),
        .RD_ADDR_B  (RD_ADDR_B),
        .WR_ADDR_A  (WR_ADDR_A),
        .WR_ADDR_B  (WR_ADDR_B),
        .WR_VALID   (WR_VALID),
        .TW_ADDR    (TW_ADDR),
        .LAYER      (LAYER),
        .LAST_LAY_O (LAST_LAY_O),
        .FFT_DONE   (FFT_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_b, m_l;
    int m_rd_a, m_rd_b, m_tw, m_layer, m_last, m_rev;
    int m_fill, m_n;
    int log_a[$];
    int log_b[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_a(input int b, input int l);
        return ((b >> l) << (l + 1)) + (b % (1 << l));
    endfunction

    function automatic int ref_tw(input int b, input int l);
        return (b % (1 << l)) << (ButtWL - l);
    endfunction

    function automatic int ref_rev(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) begin
            if (((v >> i) & 1) == 1) r = r | (1 << (AW - 1 - i));
        end
        return r;
    endfunction

    task automatic model_reset();
        m_b = 0; m_l = 0;
        m_rd_a = 0; m_rd_b = 0; m_tw = 0; m_layer = 0; m_last = 0; m_rev = 0;
        m_fill = 0; m_n = 0;
        log_a.delete();
        log_b.delete();
        log_a.push_back(0);
        log_b.push_back(0);
    endtask

    // Applies one rising edge with the currently driven inputs.
    task automatic model_edge();
        if (EN !== 1'b1) return;
        m_rd_a  = ref_a(m_b, m_l);
        m_rd_b  = m_rd_a + (1 << m_l);
        m_tw    = ref_tw(m_b, m_l);
        m_rev   = (m_l == 0) ? 1 : 0;
        m_layer = m_l;
        m_last  = (m_l == LAYERS - 1) ? 1 : 0;
        m_n++;
        log_a.push_back(m_rd_a);
        log_b.push_back(m_rd_b);
        if (ADDR_RST === 1'b1) begin
            m_fill = 0;
            m_b = 0;
            m_l = 0;
        end else begin
            if (m_fill < WR_DELAY) m_fill++;
            if (ADDR_EN === 1'b1) m_b = (m_b + 1) % BUTTERFLYES;
            if (LAY_EN === 1'b1) m_l = (m_l + 1) % LAYERS;
        end
    endtask

    task automatic check_all();
        int ea, eb, ewa, ewb, idx, edone, evld;
        ea = m_rd_a;
        eb = m_rd_b;
        if (BITREV && m_rev == 1) begin
            ea = ref_rev(m_rd_a);
            eb = ref_rev(m_rd_b);
        end
        idx = m_n - WR_DELAY;
        ewa = (idx >= 0) ? log_a[idx] : 0;
        ewb = (idx >= 0) ? log_b[idx] : 0;
        evld  = (Wr === 1'b1 && m_fill == WR_DELAY) ? 1 : 0;
        edone = (EN === 1'b1 && ADDR_RST === 1'b0 && LAY_EN === 1'b1 &&
                 m_l == LAYERS - 1) ? 1 : 0;
        chk("rd_a",     int'(RD_ADDR_A),  ea);
        chk("rd_b",     int'(RD_ADDR_B),  eb);
        chk("tw",       int'(TW_ADDR),    m_tw);
        chk("layer",    int'(LAYER),      m_layer);
        chk("last_lay", int'(LAST_LAY_O), m_last);
        chk("wr_a",     int'(WR_ADDR_A),  ewa);
        chk("wr_b",     int'(WR_ADDR_B),  ewb);
        chk("wr_valid", int'(WR_VALID),   evld);
        chk("fft_done", int'(FFT_DONE),   edone);
    endtask

    // One clock cycle: drive at negedge, check, advance model at posedge.
    task automatic step(input bit en, input bit ar, input bit ae, input bit le, input bit wr);
        @(negedge CLK);
        EN = en; ADDR_RST = ar; ADDR_EN = ae; LAY_EN = le; Wr = wr;
        #1;
        check_all();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // Holds reset with EN=1 and ADDR_EN toggling; releases with EN=0 so the
    // following edge is a no-op.
    task automatic do_reset(input int n);
        @(negedge CLK);
        RST = 1'b0; EN = 1'b1; ADDR_RST = 1'b0; LAY_EN = 1'b0; Wr = 1'b1; ADDR_EN = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            ADDR_EN = ~ADDR_EN;
            #1;
            check_all();
        end
        @(negedge CLK);
        RST = 1'b1; EN = 1'b0; ADDR_EN = 1'b0; Wr = 1'b0;
        #1;
        check_all();
    endtask

    task automatic goto_bl(input int b, input int l);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < l; i++) step(1, 0, 0, 1, 0);
        for (int i = 0; i < b; i++) step(1, 0, 1, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        do_reset(4);

        // First enabled cycle after reset
        step(1, 0, 0, 0, 0);
        chk("first_a",  int'(RD_ADDR_A), 0);
        chk("first_b",  int'(RD_ADDR_B), BITREV ? 16 : 1);
        chk("first_tw", int'(TW_ADDR),   0);

        // l=0, b=3
        goto_bl(3, 0);
        step(1, 0, 0, 0, 0);
        chk("map0_a",  int'(RD_ADDR_A), BITREV ? 12 : 6);
        chk("map0_b",  int'(RD_ADDR_B), BITREV ? 28 : 7);
        chk("map0_tw", int'(TW_ADDR),   0);
        for (int i = 0; i < WR_DELAY; i++) step(1, 0, 0, 0, 1);
        chk("map0_wa", int'(WR_ADDR_A), 6);
        chk("map0_wb", int'(WR_ADDR_B), 7);

        // l=2, b=5
        goto_bl(5, 2);
        step(1, 0, 0, 0, 0);
        chk("map2_a",  int'(RD_ADDR_A), 9);
        chk("map2_b",  int'(RD_ADDR_B), 13);
        chk("map2_tw", int'(TW_ADDR),   4);

        // Wraps of both counters in one cycle
        goto_bl(15, 4);
        step(1, 0, 0, 0, 0);
        chk("last_l4", int'(LAST_LAY_O), 1);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("wrap_a",     int'(RD_ADDR_A),  0);
        chk("wrap_layer", int'(LAYER),      0);
        chk("wrap_last",  int'(LAST_LAY_O), 0);

        // Layer-1 sweep with a 3-cycle EN gap
        goto_bl(0, 1);
        for (int i = 0; i < BUTTERFLYES; i++) begin
            step(1, 0, 1, 0, 1);
            if (i == 7) for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 1);
        end
        for (int i = 0; i < WR_DELAY + 1; i++) step(1, 0, 0, 0, 1);

        // All strobes together: ADDR_RST wins
        goto_bl(7, 2);
        step(1, 0, 0, 0, 1);
        chk("prio_pre", int'(WR_VALID), 1);
        step(1, 1, 1, 1, 1);
        chk("prio_drop", int'(WR_VALID), 0);
        for (int i = 0; i < WR_DELAY - 1; i++) step(1, 0, 1, 0, 1);
        chk("prio_still", int'(WR_VALID), 0);
        step(1, 0, 1, 0, 1);
        chk("prio_rise", int'(WR_VALID), 1);

        // Mid-operation reset
        do_reset(2);

        // Randomized strobes
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step($urandom_range(0, 9) < 8,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 9) < 6,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_iter_addr_gen.md
Name: fft_iter_addr_gen

Overview:
- Address generator that consumes the control strobes of the iterative FFT control unit: ADDR_EN, ADDR_RST, LAY_EN, Wr.
- Tracks the current layer and butterfly index.
- Produces in-place radix-2 DIT read addresses, write addresses and the twiddle-ROM address.
- Write addresses are the read addresses delayed to match the butterfly pipeline depth.

Parameters:
- LAYERS, 5, number of FFT layers (log2 N).
- BUTTERFLYES, 16, butterflies per layer (N/2).
- LayWL, 3, layer counter width.
- ButtWL, 4, butterfly counter width; data RAM address width is ButtWL+1.
- WR_DELAY, 4, number of EN-qualified cycles from a read address to its write address (range 1..8).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  clock enable; when low, all state holds.
- ADDR_RST  in  1  synchronous clear of the butterfly and layer counters.
- ADDR_EN  in  1  advance the butterfly counter.
- LAY_EN  in  1  advance the layer counter.
- Wr  in  1  write phase; qualifies WR_VALID.
- RD_ADDR_A  out  ButtWL+1  upper-input read address.
- RD_ADDR_B  out  ButtWL+1  lower-input read address.
- WR_ADDR_A  out  ButtWL+1  delayed RD_ADDR_A.
- WR_ADDR_B  out  ButtWL+1  delayed RD_ADDR_B.
- WR_VALID  out  1  Wr AND delay line full.
- TW_ADDR  out  ButtWL  twiddle ROM index.
- LAYER  out  LayWL  current layer counter.
- LAST_LAY_O  out  1  high while LAYER == LAYERS-1.
- FFT_DONE  out  1  one-cycle pulse on layer wrap.

Behaviour:
- Reset (RST=0, async): b=0, l=0; all outputs 0; delay line cleared; fill count 0.
- Counters update only when EN=1. Priority: ADDR_RST > ADDR_EN/LAY_EN.
  - ADDR_RST: b<=0, l<=0, delay-line fill count <=0. Delay-line contents are not cleared.
  - ADDR_EN: b<=b+1; b wraps from BUTTERFLYES-1 to 0.
  - LAY_EN: l<=l+1; l wraps from LAYERS-1 to 0, and FFT_DONE=1 for that cycle.
  - ADDR_EN and LAY_EN in the same cycle: both apply independently.
- Address function (combinational on b, l), registered into RD_ADDR_*/TW_ADDR on every EN cycle. Outputs lag the counters by one cycle.
  - A = {b[ButtWL-1:l], 1'b0, b[l-1:0]}, i.e. a 0 inserted at bit position l.
  - B = A | (1<<l).
  - TW = (b mod 2^l) << (ButtWL-l). At l=0, TW=0.
- Write delay line: WR_DELAY-stage shift register of {A, B}, shifting on every EN=1 cycle.
  - WR_ADDR_* = last stage of the shift register.
  - Fill count saturates at WR_DELAY.
  - WR_VALID = Wr & (fill == WR_DELAY).
- EN=0 freezes counters, registered outputs and the delay line. FFT_DONE is 0 while EN=0.
- LAST_LAY_O is registered with LAYER; both update together, one cycle after l.
- Reset asserted mid-operation aborts immediately and returns to the reset values.
- Out-of-range widths (BUTTERFLYES > 2^ButtWL, LAYERS > 2^LayWL) are a configuration error, flagged by a simulation-only $error.

Optional Feature:
- Macro: FFT_ADDR_BITREV_EN.
- Defined: during layer 0 only, RD_ADDR_A and RD_ADDR_B are bit-reversed over ButtWL+1 bits, so in-order input data is read in DIT order. WR addresses are taken from the unreversed values. TW_ADDR is unaffected.
- Undefined: no reversal; input data must be pre-permuted in RAM.

Test Plan:
- Reset: hold RST=0 with EN=1 and ADDR_EN pulsing -> all outputs 0. Release RST; first EN cycle -> RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0.
- Address map, defaults: l=0, b=3 -> next cycle RD_ADDR_A=6, RD_ADDR_B=7, TW_ADDR=0. l=2, b=5 -> RD_ADDR_A=9, RD_ADDR_B=13, TW_ADDR=4.
- Wrap: b=15 + ADDR_EN -> b=0. l=4 + LAY_EN -> LAYER=0 and FFT_DONE high exactly 1 cycle. LAST_LAY_O high for all of l=4.
- Delay: WR_DELAY=4, sweep b=0..15 in layer 1 with Wr=1 -> WR_ADDR_A equals RD_ADDR_A from 4 EN cycles earlier; WR_VALID rises on the 4th EN cycle. Inserting 3 EN=0 cycles mid-sweep shifts the alignment by 0.
- Priority: ADDR_RST, ADDR_EN and LAY_EN together at b=7, l=2 -> b=0, l=0, WR_VALID drops and re-rises after 4 EN cycles.
- FFT_ADDR_BITREV_EN defined: l=0, b=3 -> RD_ADDR_A=12 (00110 reversed to 01100), RD_ADDR_B=28, WR_ADDR_A=6 after the delay. At l=1 there is no reversal.
